// File: rtl/camera_pwr_pkg.sv
// Shared state encoding, helper function and default timing for the camera power sequencer.
package camera_pwr_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_UP_DLY = 3'd1,
    ST_UP_PG  = 3'd2,
    ST_ON     = 3'd3,
    ST_DN_DLY = 3'd4,
    ST_FAULT  = 3'd5
  } pwr_state_e;

  localparam int          DEF_NUM_STEPS  = 5;
  localparam int          DEF_CNT_W      = 32;
  localparam logic [31:0] DEF_UP_DELAY   = 32'd1000000;
  localparam logic [31:0] DEF_DOWN_DELAY = 32'd1000000;
  localparam logic [31:0] DEF_PG_TIMEOUT = 32'd2000000;
  localparam logic [4:0]  DEF_PG_MASK    = 5'b00111;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/pwr_step_timer.sv
// Saturating phase counter shared by the delay, PG-wait and power-down phases.
module pwr_step_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             done_o
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i)             r_cnt <= '0;
    else if (en_i && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign done_o = (r_cnt >= limit_i);

endmodule

// File: rtl/camera_power_sequencer.sv
// Ordered power-up / reverse power-down of the camera rails, INCK_EN and XCLR,
// with power-good supervision and a latched fault that needs an explicit clear.
module camera_power_sequencer
  import camera_pwr_pkg::*;
#(
  parameter int                         NUM_STEPS    = DEF_NUM_STEPS,
  parameter int                         CNT_W        = DEF_CNT_W,
  parameter logic [NUM_STEPS*CNT_W-1:0] UP_DELAY_VEC = {NUM_STEPS{DEF_UP_DELAY}},
  parameter logic [CNT_W-1:0]           DOWN_DELAY   = DEF_DOWN_DELAY,
  parameter logic [NUM_STEPS-1:0]       PG_MASK      = DEF_PG_MASK,
  parameter logic [CNT_W-1:0]           PG_TIMEOUT   = DEF_PG_TIMEOUT,
  localparam int SW = (clog2(NUM_STEPS) < 1) ? 1 : clog2(NUM_STEPS)
) (
  input  logic                 ctrl_clk_i,
  input  logic                 ctrl_rst_i,
  input  logic                 pwr_req_i,
  input  logic                 fault_clr_i,
  input  logic [NUM_STEPS-1:0] pg_i,
  output logic [NUM_STEPS-1:0] en_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 fault_o,
  output logic [SW-1:0]        fault_step_o
);

  pwr_state_e           r_state, w_nxt_state;
  logic [SW-1:0]        r_step, w_nxt_step, r_fstep, w_nxt_fstep, w_fault_idx;
  logic [NUM_STEPS-1:0] r_en, w_nxt_en, w_pg_bad, w_rem;
  logic                 r_fault, w_nxt_fault, r_abort, w_nxt_abort;
  logic                 w_go_dn, w_go_fault, w_pg_ok, w_busy, w_tmr_clr, w_tmr_done;
  logic [CNT_W-1:0]     w_up_delay, w_tmr_limit;

  // Timer fires when count reaches limit, so a delay of N cycles loads N-1 (0 acts as 1).
  function automatic logic [CNT_W-1:0] minus1(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  function automatic logic [SW-1:0] hi_idx(input logic [NUM_STEPS-1:0] v);
    logic [SW-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_STEPS; k++) if (v[k]) r = SW'(k);
    return r;
  endfunction

  function automatic logic [SW-1:0] lo_idx(input logic [NUM_STEPS-1:0] v);
    logic [SW-1:0] r;
    r = '0;
    for (int k = NUM_STEPS - 1; k >= 0; k--) if (v[k]) r = SW'(k);
    return r;
  endfunction

  always_comb begin
    w_up_delay = UP_DELAY_VEC[CNT_W-1:0];
    for (int k = 0; k < NUM_STEPS; k++)
      if (r_step == SW'(k)) w_up_delay = UP_DELAY_VEC[k*CNT_W +: CNT_W];
  end

  always_comb begin
    case (r_state)
      ST_UP_DLY: w_tmr_limit = minus1(w_up_delay);
      ST_UP_PG:  w_tmr_limit = minus1(PG_TIMEOUT);
      default:   w_tmr_limit = minus1(DOWN_DELAY);
    endcase
  end

  assign w_pg_ok  = !PG_MASK[r_step] || pg_i[r_step];
  assign w_pg_bad = PG_MASK & ~pg_i & r_en;
  assign w_busy   = (r_state == ST_UP_DLY) || (r_state == ST_UP_PG) || (r_state == ST_DN_DLY);

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_step    = r_step;
    w_nxt_en      = r_en;
    w_nxt_fault   = r_fault;
    w_nxt_fstep   = r_fstep;
    w_nxt_abort   = r_abort;
    w_go_dn       = 1'b0;
    w_go_fault    = 1'b0;
    w_fault_idx   = r_step;
    w_rem         = r_en;
    w_rem[r_step] = 1'b0;
    case (r_state)
      ST_OFF:
        if (pwr_req_i && !r_fault) begin
          w_nxt_state = ST_UP_DLY;
          w_nxt_step  = '0;
          w_nxt_abort = 1'b0;
        end
      ST_UP_DLY:
        if (!pwr_req_i) w_go_dn = 1'b1;
        else if (w_tmr_done) begin
          w_nxt_en[r_step] = 1'b1;
          w_nxt_state      = ST_UP_PG;
        end
      ST_UP_PG:
        if (!w_pg_ok && w_tmr_done) w_go_fault = 1'b1;
        else if (!pwr_req_i) w_go_dn = 1'b1;
        else if (w_pg_ok) begin
          if (r_step == SW'(NUM_STEPS - 1)) w_nxt_state = ST_ON;
          else begin
            w_nxt_step  = r_step + SW'(1);
            w_nxt_state = ST_UP_DLY;
          end
        end
      ST_ON:
        if (|w_pg_bad) begin
          w_go_fault  = 1'b1;
          w_fault_idx = lo_idx(w_pg_bad);
        end else if (!pwr_req_i) w_go_dn = 1'b1;
      ST_DN_DLY:
        // A step that is already off is dropped without waiting out the delay.
        if (w_tmr_done || !r_en[r_step]) begin
          w_nxt_en = w_rem;
          if (|w_rem) w_nxt_step = hi_idx(w_rem);
          else        w_nxt_state = r_abort ? ST_FAULT : ST_OFF;
        end
      ST_FAULT: begin
        w_nxt_en = '0;
        if (fault_clr_i && !pwr_req_i) begin
          w_nxt_state = ST_OFF;
          w_nxt_fault = 1'b0;
          w_nxt_abort = 1'b0;
        end
      end
      default: begin
        w_nxt_state = ST_FAULT;
        w_nxt_en    = '0;
      end
    endcase
    if (w_go_fault) begin
      w_nxt_fault = 1'b1;
      w_nxt_fstep = w_fault_idx;
      w_nxt_abort = 1'b1;
    end
    if (w_go_dn || w_go_fault) begin
      if (|r_en) begin
        w_nxt_state = ST_DN_DLY;
        w_nxt_step  = hi_idx(r_en);
      end else w_nxt_state = w_go_fault ? ST_FAULT : ST_OFF;
    end
  end

  // Every phase or step change restarts the shared timer.
  assign w_tmr_clr = (w_nxt_state != r_state) || (w_nxt_step != r_step);

  pwr_step_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i   (ctrl_clk_i),
    .rst_i   (ctrl_rst_i),
    .clr_i   (w_tmr_clr),
    .en_i    (w_busy),
    .limit_i (w_tmr_limit),
    .done_o  (w_tmr_done)
  );

  always_ff @(posedge ctrl_clk_i) begin
    if (ctrl_rst_i) begin
      r_state <= ST_OFF;
      r_step  <= '0;
      r_en    <= '0;
      r_fault <= 1'b0;
      r_fstep <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_step  <= w_nxt_step;
      r_en    <= w_nxt_en;
      r_fault <= w_nxt_fault;
      r_fstep <= w_nxt_fstep;
      r_abort <= w_nxt_abort;
    end
  end

  assign en_o         = r_en;
  assign ready_o      = (r_state == ST_ON);
  assign busy_o       = w_busy;
  assign fault_o      = r_fault;
  assign fault_step_o = r_fstep;

endmodule
